fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
// - Write-side scheduler for async_fifo: shares the single FIFO write port (wr_en/wdata/wfull)
//   among NUM_REQ requesters in the wclk domain, granting round-robin bursts of up to MAX_BURST words.
// - Sits between producer blocks and the FIFO write interface; read side untouched.
// PARAMETERS
// - DATA_WIDTH  8  width of each data word (matches FIFO DATA_WIDTH)
// - NUM_REQ     4  number of requesters, >=2
// - MAX_BURST   4  max words per grant, >=1
// PORTS
// - wclk        in   1                   write-domain clock
// - wrst        in   1                   reset, synchronous, active-high
// - req_valid   in   NUM_REQ             per-requester word valid
// - req_data    in   NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
// - req_last    in   NUM_REQ             word is last of requester's burst
// - req_ready   out  NUM_REQ             word accepted when req_valid[i] & req_ready[i]
// - grant       out  NUM_REQ             one-hot current owner, registered
// - busy        out  1                   state == BURST
// - wr_en       out  1                   FIFO write enable
// - wdata       out  DATA_WIDTH          FIFO write data
// - wfull       in   1                   FIFO full flag (wclk domain)
// BEHAVIOUR
// - Reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0 -> req_ready=0, wr_en=0, busy=0, wdata=0.
// - FSM IDLE: if |req_valid, pick first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ);
//   register grant one-hot, beat_cnt=0, go BURST. 1-cycle arbitration bubble; no transfer in IDLE.
// - FSM BURST (owner g): req_ready[g]=!wfull; other req_ready bits 0.
//   transfer = req_valid[g] & !wfull; wr_en=transfer; wdata=req_data[g] (combinational from grant).
//   On transfer beat_cnt++. Release after a transfer with req_last[g]=1 or beat_cnt==MAX_BURST-1.
//   Release also if req_valid[g]=0 in BURST (owner gone idle, no deadlock).
//   Release: grant=0, rr_ptr=(g+1) mod NUM_REQ, go IDLE.
// - wfull=1 in BURST: no transfer, grant/beat_cnt frozen, no timeout; resumes when wfull falls.
// - Invariant: wr_en never 1 while wfull=1; wr_en=0 whenever grant==0.
// - Requests in IDLE are never lost: req_valid must be held by producer until req_ready.
// - beat_cnt width $clog2(MAX_BURST+1); MAX_BURST=1 -> one word per grant.
// - Reset mid-burst: next edge returns to reset state; words already written remain in FIFO;
//   remainder of burst not written; arbitration restarts at requester 0.
// CONFIGURATION
// - Macro FIFO_WR_ARB_STATS_EN defined: adds outputs wr_cnt[15:0] (count of wr_en cycles)
//   and stall_cnt[15:0] (cycles in BURST with req_valid[g]=1 & wfull=1); both saturate at
//   16'hFFFF, cleared by wrst.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: wrst=1 for 2 cycles with all req_valid=1 -> grant=0, wr_en=0, req_ready=0, busy=0.
// - Single: only req 1 sends 0x11,0x12,0x13 (last on 0x13) -> grant=4'b0010 one cycle after
//   req_valid, wr_en 3 cycles, wdata 0x11,0x12,0x13, then IDLE with rr_ptr=2.
// - Fairness: all 4 continuously valid, never last, MAX_BURST=4 -> grants 0,1,2,3,0 each
//   exactly 4 writes, 1 idle cycle between grants.
// - Back-pressure: wfull=1 for 5 cycles after beat 2 -> wr_en=0, req_ready=0, grant held;
//   after wfull=0 remaining 2 beats written, total 4.
// - Reset mid-burst: wrst=1 at beat 2 of req 2 -> next cycle grant=0, wr_en=0; after release
//   with all valid, first grant=4'b0001.
// - Stats (FIFO_WR_ARB_STATS_EN): previous back-pressure case -> wr_cnt=4, stall_cnt=5.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler for async_fifo: grants bursts of up to MAX_BURST words
// to one of NUM_REQ producers. Optional stats counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   wr_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 transfer;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // First valid requester at or after rr_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[wrap_idx(rr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(rr_q, k);
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];

  // Handshake: a word moves when req_valid[i] & req_ready[i] are both high at a wclk edge;
  // the producer holds valid/data/last stable until then. Ready is only offered to the
  // owner and only while the FIFO has room, so wr_en is exactly that handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    beat_d   = beat_q;
    transfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        transfer = owner_valid & !wfull;
        if (!owner_valid || (transfer && (owner_last || beat_q == BW'(MAX_BURST - 1)))) begin
          grant_d = '0;
          rr_d    = wrap_idx(owner_q, 1);
          state_d = IDLE;
        end else if (transfer) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // Data mux keyed off the registered one-hot grant; all-zero grant yields zero data.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign busy      = (state_q == BURST);
  assign grant     = grant_q;
  assign wr_en     = transfer;
  assign req_ready = (busy && !wfull) ? grant_q : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (wr_en && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (busy && owner_valid && wfull && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
